demux1x4_pipe: RTL and testbench

//  1-to-4 registered demultiplexer with valid/ready handshake; the write-side

---
 rtl/demux1x4_pipe.sv | 141 ++++++++++++++
 tb/tb_demux1x4_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1x4_pipe.sv
// demux1x4_pipe: 1-to-4 registered demultiplexer with per-channel valid/ready.
// A 2-bit select captured with each word steers it to channel a..d.
// Each channel holds its word until that consumer accepts it.
// Optional build macro DEMUX1X4_REG_READY_EN: each channel gains a skid entry
// so in_ready comes from registered state only (no out_ready -> in_ready path).
module demux1x4_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             busy
);

  localparam int unsigned NCH = 4;

  logic [NCH-1:0]   full_q, full_d;
  logic [WIDTH-1:0] data_q [NCH];
  logic [WIDTH-1:0] data_d [NCH];
  logic             busy_q;
  logic             in_fire;
  logic [NCH-1:0]   in_hit;
  logic [NCH-1:0]   out_fire;

  // Handshake decode: which channel receives the input word, which drain
  assign in_fire  = in_valid & in_ready;
  assign in_hit   = in_fire ? (NCH'(1) << in_sel) : '0;
  assign out_fire = full_q & out_ready;

`ifdef DEMUX1X4_REG_READY_EN

  logic [NCH-1:0]   skid_q, skid_d;
  logic [WIDTH-1:0] skid_data_q [NCH];
  logic [WIDTH-1:0] skid_data_d [NCH];

  // Ready depends only on the addressed channel's skid occupancy
  assign in_ready = rst_n & ~skid_q[in_sel];

  // Next-state for main + skid entries; FIFO order main before skid
  always_comb begin
    full_d = full_q;
    skid_d = skid_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      data_d[i]      = data_q[i];
      skid_data_d[i] = skid_data_q[i];
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (skid_q[i]) begin
        // Skid full implies no input for this channel; refill main on drain
        if (out_fire[i]) begin
          data_d[i] = skid_data_q[i];
          skid_d[i] = 1'b0;
        end
      end else if (full_q[i]) begin
        if (in_hit[i] && out_fire[i]) begin
          data_d[i] = in_data;
        end else if (in_hit[i]) begin
          skid_d[i]      = 1'b1;
          skid_data_d[i] = in_data;
        end else if (out_fire[i]) begin
          full_d[i] = 1'b0;
        end
      end else if (in_hit[i]) begin
        full_d[i] = 1'b1;
        data_d[i] = in_data;
      end
    end
  end

  // Skid entry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        skid_data_q[i] <= '0;
      end
    end else begin
      skid_q <= skid_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        skid_data_q[i] <= skid_data_d[i];
      end
    end
  end

`else

  // Addressed channel can take a word if empty or draining this cycle
  assign in_ready = rst_n & (~full_q[in_sel] | out_ready[in_sel]);

  // Next-state per single-entry channel; new word wins over a same-cycle drain
  always_comb begin
    full_d = full_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      data_d[i] = data_q[i];
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (in_hit[i]) begin
        full_d[i] = 1'b1;
        data_d[i] = in_data;
      end else if (out_fire[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

`endif

  // Main entry and busy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      busy_q <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      busy_q <= |full_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = full_q;
  assign busy      = busy_q;
  assign out_a     = data_q[0];
  assign out_b     = data_q[1];
  assign out_c     = data_q[2];
  assign out_d     = data_q[3];

endmodule

// File: tb/tb_demux1x4_pipe.sv
// Testbench for demux1x4_pipe: vector table, hand sequences for the
// multi-cycle corners, and a random run against a per-channel queue model.
module tb_demux1x4_pipe;

  localparam int W = 32;
`ifdef DEMUX1X4_REG_READY_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         busy;

  demux1x4_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: each channel is a queue of up to CAP words
  logic [W-1:0] mem   [4][2];
  int           cnt   [4];
  logic [W-1:0] shown [4];

  typedef struct {
    logic         v;
    logic [1:0]   sel;
    logic [W-1:0] data;
    logic [3:0]   rdy;
    logic         exp_ready;
    logic [3:0]   exp_valid;
    logic [W-1:0] exp_word;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dut_out(input int ch);
    case (ch)
      0: return out_a;
      1: return out_b;
      2: return out_c;
      default: return out_d;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      cnt[c] = 0;
      shown[c] = '0;
    end
  endtask

  function automatic logic model_ready(input logic [1:0] s, input logic [3:0] r);
    if (CAP == 1) return (cnt[s] == 0) || r[s];
    return cnt[s] < CAP;
  endfunction

  task automatic check_outputs();
    logic [3:0] ev;
    for (int c = 0; c < 4; c++) ev[c] = (cnt[c] > 0);
    chk("out_valid", W'(out_valid), W'(ev));
    chk("busy", W'(busy), W'(|ev));
    for (int c = 0; c < 4; c++) chk($sformatf("out_data[%0d]", c), dut_out(c), shown[c]);
  endtask

  // One clock: drive at negedge, check in_ready, clock, check outputs at negedge
  task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                      input logic [3:0] r, output logic rdy_seen);
    logic mr;
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
    #1;
    mr = model_ready(s, r);
    chk("in_ready", W'(in_ready), W'(mr));
    rdy_seen = in_ready;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      if (cnt[c] > 0 && r[c]) begin
        mem[c][0] = mem[c][1];
        cnt[c]--;
      end
    end
    if (v && mr) begin
      mem[s][cnt[s]] = d;
      cnt[s]++;
    end
    for (int c = 0; c < 4; c++) if (cnt[c] > 0) shown[c] = mem[c][0];
    @(negedge clk);
    check_outputs();
  endtask

  logic         rs;
  logic         hv;
  logic [1:0]   hs;
  logic [W-1:0] hd;
  logic [3:0]   hr;

  initial begin
    // Vector table: steering, streaming, same-cycle replace (all from empty)
    vecs.push_back('{1'b1, 2'd2, 32'hDEADBEEF, 4'hF, 1'b1, 4'b0100, 32'hDEADBEEF});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b1, 2'(i % 4), 32'h100 + W'(i), 4'hF, 1'b1, 4'(1 << (i % 4)), 32'h100 + W'(i)});
    vecs.push_back('{1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 4'b0000, 32'h10C});
    vecs.push_back('{1'b1, 2'd0, 32'hA1, 4'hE, 1'b1, 4'b0001, 32'hA1});
    vecs.push_back('{1'b1, 2'd0, 32'hA2, 4'h1, 1'b1, 4'b0001, 32'hA2});
    vecs.push_back('{1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 4'b0000, 32'hA2});

    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset out_valid", W'(out_valid), '0);
    chk("reset busy", W'(busy), '0);
    chk("reset in_ready", W'(in_ready), '0);
    chk("reset out_d", out_d, '0);
    rst_n = 1'b1;

    // T1: async reset while channel c holds a word and a transfer is offered
    step(1'b1, 2'd2, 32'hC0, 4'h0, rs);
    chk("T1 pre out_valid", W'(out_valid), W'(4'b0100));
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hAB; out_ready = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("T1 out_valid", W'(out_valid), '0);
    chk("T1 busy", W'(busy), '0);
    chk("T1 out_c", out_c, '0);
    chk("T1 in_ready", W'(in_ready), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd0, 32'h5A, 4'hF, rs);
    chk("T1 first word", out_a, 32'h5A);
    step(1'b0, 2'd0, '0, 4'hF, rs);

    // T2/T4/T5 from the vector table
    foreach (vecs[k]) begin
      step(vecs[k].v, vecs[k].sel, vecs[k].data, vecs[k].rdy, rs);
      chk($sformatf("vec%0d in_ready", k), W'(rs), W'(vecs[k].exp_ready));
      chk($sformatf("vec%0d out_valid", k), W'(out_valid), W'(vecs[k].exp_valid));
      chk($sformatf("vec%0d word", k), dut_out(int'(vecs[k].sel)), vecs[k].exp_word);
    end

    // T3: channel b stalled blocks only words for b
    step(1'b1, 2'd1, 32'h11, 4'b1101, rs);
    chk("T3 b valid", W'(out_valid), W'(4'b0010));
    step(1'b0, 2'd1, 32'h33, 4'b1101, rs);
    chk("T3 b blocked", W'(rs), W'(CAP == 2));
    step(1'b1, 2'd3, 32'h22, 4'b0101, rs);
    chk("T3 d accepted", W'(rs), 1);
    chk("T3 d out", out_d, 32'h22);
    chk("T3 b still 11", out_b, 32'h11);
    step(1'b0, 2'd1, 32'h0, 4'b1101, rs);
    step(1'b1, 2'd1, 32'h33, 4'b1111, rs);
    chk("T3 held word", out_b, 32'h33);
    step(1'b0, 2'd0, 32'h0, 4'hF, rs);
    chk("T3 drained", W'(out_valid), '0);

`ifdef DEMUX1X4_REG_READY_EN
    // T6: two words buffer in a stalled channel, the third waits
    step(1'b1, 2'd3, 32'h61, 4'b0111, rs);
    chk("T6 w1", W'(rs), 1);
    step(1'b1, 2'd3, 32'h62, 4'b0111, rs);
    chk("T6 w2", W'(rs), 1);
    step(1'b1, 2'd3, 32'h63, 4'b0111, rs);
    chk("T6 w3 stall", W'(rs), 0);
    chk("T6 head", out_d, 32'h61);
    step(1'b1, 2'd3, 32'h63, 4'b1111, rs);
    chk("T6 w3 still stalled", W'(rs), 0);
    chk("T6 second", out_d, 32'h62);
    step(1'b1, 2'd3, 32'h63, 4'b1111, rs);
    chk("T6 w3 accepted", W'(rs), 1);
    chk("T6 third", out_d, 32'h63);
    step(1'b0, 2'd0, 32'h0, 4'hF, rs);
`endif

    // Random run; producer holds its word while stalled
    hv = 1'b0; hs = '0; hd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!(hv && !rs)) begin
        hv = ($urandom_range(0, 3) != 0);
        hs = 2'($urandom_range(0, 3));
        hd = W'($urandom);
      end
      hr = 4'($urandom) | 4'($urandom);
      step(hv, hs, hd, hr, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
